// File: rtl/mch_enc_frame_tx.sv
// Manchester frame transmitter: serialises len DW-bit words (plus optional checksum)
// onto txsdo, one half-bit symbol per rising edge of pls_1m.
module mch_enc_frame_tx #(
    parameter int DW        = 8,
    parameter int MAX_WORDS = 16,
    parameter int LEN_W     = 5,
    parameter int MSB_FIRST = 1,
    parameter int MCH_POL   = 0,
    parameter int APPEND_CS = 1,
    parameter int IDLE_LVL  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pls_1m,
    input  logic             sync_done,
    input  logic             tx_abort,
    input  logic [LEN_W-1:0] frm_len,
    input  logic [DW-1:0]    p_data,
    output logic [LEN_W-1:0] d_sel,
    output logic             txsdo,
    output logic             busy,
    output logic             p2s_end
);

    localparam int               BW      = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [LEN_W-1:0] MAXW    = LEN_W'(MAX_WORDS);
    localparam logic             IDLE_V  = (IDLE_LVL != 0);
    localparam logic             INV     = (MCH_POL == 0);
    localparam logic             HAS_CS  = (APPEND_CS != 0);
    localparam logic [BW-1:0]    LAST_BIT = BW'(DW - 1);

    typedef enum logic [1:0] {S_IDLE, S_FIRST_HALF, S_SECOND_HALF, S_FINISH} state_t;

    state_t           r_state, w_state_next;
    logic             r_pl0, r_pl1, r_sd0, r_sd1;
    logic [LEN_W-1:0] r_len, w_len_next;
    logic [LEN_W-1:0] r_widx, w_widx_next;
    logic [LEN_W-1:0] r_dsel, w_dsel_next;
    logic [BW-1:0]    r_bit, w_bit_next;
    logic [DW-1:0]    r_shift, w_shift_next;
    logic [DW-1:0]    r_cs, w_cs_next;
    logic             r_txsdo, w_txsdo_next;
    logic             r_busy, w_busy_next;
    logic             r_p2s_end, w_p2s_end_next;

    logic             w_tick, w_start, w_is_cs, w_head_cur, w_head_reg;
    logic [DW-1:0]    w_load, w_word;
    logic [LEN_W:0]   w_widx_inc, w_total;

    assign w_tick     = r_pl0 & ~r_pl1;
    assign w_start    = r_sd0 & ~r_sd1;
    assign w_is_cs    = HAS_CS && (r_widx == r_len);
    assign w_load     = w_is_cs ? r_cs : p_data;
    // At bit 0 the word is taken straight from the source so it goes out this tick
    assign w_word     = (r_bit == '0) ? w_load : r_shift;
    assign w_head_cur = (MSB_FIRST != 0) ? w_word[DW-1] : w_word[0];
    assign w_head_reg = (MSB_FIRST != 0) ? r_shift[DW-1] : r_shift[0];
    assign w_widx_inc = {1'b0, r_widx} + (LEN_W+1)'(1);
    assign w_total    = {1'b0, r_len} + (LEN_W+1)'(HAS_CS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_pl0     <= 1'b0;
            r_pl1     <= 1'b0;
            r_sd0     <= 1'b0;
            r_sd1     <= 1'b0;
            r_len     <= '0;
            r_widx    <= '0;
            r_dsel    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_cs      <= '0;
            r_txsdo   <= IDLE_V;
            r_busy    <= 1'b0;
            r_p2s_end <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pl0     <= pls_1m;
            r_pl1     <= r_pl0;
            r_sd0     <= sync_done;
            r_sd1     <= r_sd0;
            r_len     <= w_len_next;
            r_widx    <= w_widx_next;
            r_dsel    <= w_dsel_next;
            r_bit     <= w_bit_next;
            r_shift   <= w_shift_next;
            r_cs      <= w_cs_next;
            r_txsdo   <= w_txsdo_next;
            r_busy    <= w_busy_next;
            r_p2s_end <= w_p2s_end_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_len_next     = r_len;
        w_widx_next    = r_widx;
        w_dsel_next    = r_dsel;
        w_bit_next     = r_bit;
        w_shift_next   = r_shift;
        w_cs_next      = r_cs;
        w_txsdo_next   = r_txsdo;
        w_busy_next    = r_busy;
        w_p2s_end_next = 1'b0;

        if (r_state != S_IDLE && tx_abort) begin
            w_state_next = S_IDLE;
            w_txsdo_next = IDLE_V;
            w_busy_next  = 1'b0;
            w_dsel_next  = '0;
            w_bit_next   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start && frm_len != '0) begin
                        w_len_next   = (frm_len > MAXW) ? MAXW : frm_len;
                        w_widx_next  = '0;
                        w_dsel_next  = '0;
                        w_bit_next   = '0;
                        w_cs_next    = '0;
                        w_busy_next  = 1'b1;
                        w_state_next = S_FIRST_HALF;
                    end
                end
                S_FIRST_HALF: begin
                    if (w_tick) begin
                        w_shift_next = w_word;
                        if (r_bit == '0 && !w_is_cs)
                            w_cs_next = r_cs + p_data;
                        w_txsdo_next = w_head_cur ^ INV;
                        w_state_next = S_SECOND_HALF;
                    end
                end
                S_SECOND_HALF: begin
                    if (w_tick) begin
                        w_txsdo_next = ~w_head_reg ^ INV;
                        w_shift_next = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
                        if (r_bit == LAST_BIT) begin
                            w_bit_next   = '0;
                            w_widx_next  = w_widx_inc[LEN_W-1:0];
                            w_dsel_next  = r_dsel + LEN_W'(1);
                            w_state_next = (w_widx_inc < w_total) ? S_FIRST_HALF : S_FINISH;
                        end else begin
                            w_bit_next   = r_bit + BW'(1);
                            w_state_next = S_FIRST_HALF;
                        end
                    end
                end
                S_FINISH: begin
                    if (w_tick) begin
                        w_txsdo_next   = IDLE_V;
                        w_busy_next    = 1'b0;
                        w_p2s_end_next = 1'b1;
                        w_dsel_next    = '0;
                        w_state_next   = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign d_sel   = r_dsel;
    assign txsdo   = r_txsdo;
    assign busy    = r_busy;
    assign p2s_end = r_p2s_end;

endmodule

// File: doc/mch_enc_frame_tx.md
Name: mch_enc_frame_tx

Overview:
Parametrised Manchester frame transmitter that serialises a variable-length burst of DW-bit words onto one line.
- Generalises the fixed 7-byte, 8-bit encoder/P2S pair into one block.
- Adds configurable word width, run-time frame length, selectable Manchester polarity, optional appended checksum word, and abort.
- Sits between the frame-buffer mux (driven via d_sel/p_data) and the line driver; started by the sync generator's sync_done.

Parameters:
DW, 8, data word width in bits (>=2)
MAX_WORDS, 16, maximum data words per frame (>=1)
LEN_W, 5, width of frm_len and d_sel; must satisfy 2^LEN_W > MAX_WORDS
MSB_FIRST, 1, 1 = word MSB sent first, 0 = LSB first
MCH_POL, 0, 0 = IEEE (1 sent low-then-high, 0 sent high-then-low); 1 = inverted (G.E. Thomas)
APPEND_CS, 1, 1 = append one checksum word after the data words
IDLE_LVL, 1, txsdo level when not transmitting

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
pls_1m  input  1  half-bit timing pulse, each rising edge = one half-bit tick
sync_done  input  1  frame start; rising edge starts a frame
tx_abort  input  1  synchronous abort, level-sensitive
frm_len  input  LEN_W  data words in frame; sampled at start
p_data  input  DW  word selected by d_sel
d_sel  output  LEN_W  index of word requested from upstream mux
txsdo  output  1  Manchester serial output, registered
busy  output  1  high while a frame is in progress
p2s_end  output  1  one-clk pulse at normal frame completion

Behaviour:
- Reset (rst=0, async): txsdo=IDLE_LVL, busy=0, p2s_end=0, d_sel=0; all edge-detect flops 0; state IDLE; checksum accumulator 0.
- Edge detection:
  - pls_1m and sync_done each pass through two flops (x0 <= in, x1 <= x0).
  - tick = pl0 & ~pl1; start = sd0 & ~sd1; each is a single-clk event.
  - Minimum pls_1m period is 4 clk.
- States: IDLE, FIRST_HALF, SECOND_HALF, FINISH.
- IDLE:
  - On start with frm_len != 0: latch len = min(frm_len, MAX_WORDS), set word index = 0, d_sel = 0, clear checksum, busy = 1, go to FIRST_HALF armed for the first word.
  - frm_len == 0 or start while busy: ignored.
- FIRST_HALF, on tick:
  - At bit 0 of a word: load the shift register from p_data (or checksum), add the loaded data word to the checksum (mod 2^DW).
  - Drive txsdo with the first half-bit symbol.
  - Go to SECOND_HALF.
- SECOND_HALF, on tick:
  - Drive txsdo with the second half-bit symbol.
  - If not the last bit: advance the bit counter, go to FIRST_HALF.
  - If the last bit of a word: increment word index and d_sel; go to FIRST_HALF if more words remain (including the checksum word when APPEND_CS=1), else go to FINISH.
  - d_sel is therefore stable >= 1 half-bit period before p_data is sampled.
- Half-bit symbols:
  - MCH_POL=0: bit 1 -> (0,1); bit 0 -> (1,0). MCH_POL=1 inverts both halves.
- Checksum word:
  - Sent after the data words when APPEND_CS=1.
  - Value = sum of all data words mod 2^DW.
  - d_sel = len during this word; p_data is ignored.
- FINISH, on tick:
  - txsdo = IDLE_LVL, busy = 0, p2s_end = 1 for exactly one clk, d_sel = 0, go to IDLE.
- Latency: txsdo changes on the clk edge after the tick cycle, i.e. the 2nd clk edge after pls_1m is first sampled high.
- Frame duration: (len + APPEND_CS) * DW * 2 ticks of data, plus 1 tick to reach FINISH.
- tx_abort=1 in any non-IDLE state:
  - Next clk: IDLE, txsdo = IDLE_LVL, busy = 0, d_sel = 0; no p2s_end.
  - Abort takes priority over a coincident tick or start.
- Async reset mid-frame: immediate return to reset values; no p2s_end.
- sync_done held high: only the rising edge counts; no retrigger.

Test Plan:
1. DW=8, MSB_FIRST=1, MCH_POL=0, APPEND_CS=1; frm_len=2, words 0xA5, 0x3C -> first 8 half-bits 0,1,1,0,0,1,1,0; third word sent = 0xE1; p2s_end pulses once, 1 clk, on tick 49; busy high for exactly 48 ticks + finish.
2. APPEND_CS=0, frm_len=1, p_data=0x00, MCH_POL=1 -> 16 half-bits alternating 0,1 (eight (0,1) pairs); d_sel goes 0 -> 1 -> 0; txsdo returns to 1 after tick 17.
3. frm_len=0 with start -> busy stays 0, txsdo stays IDLE_LVL, no p2s_end; frm_len=20 (MAX_WORDS=16) -> exactly 16 data words + checksum sent.
4. tx_abort asserted at tick 10 of the frame -> next clk: txsdo=1, busy=0, d_sel=0; no p2s_end; a new start then transmits a correct frame from word 0.
5. rst driven low mid-word with no clk edge -> outputs reach reset values immediately; a second sync_done edge during busy does not restart the frame or alter d_sel.
6. LSB_FIRST (MSB_FIRST=0), DW=4, word 0x1 -> half-bits 0,1,1,0,1,0,1,0.
